// File: rtl/vad_pkg.sv
// Shared VAD front-end constants and the packed feature-word type.
package vad_pkg;

   localparam int unsigned FEAT_W          = 20;
   localparam int unsigned FIELD_W         = 5;
   localparam int unsigned FIELDS_PER_WORD = 4;
   localparam int unsigned FIFO_DEPTH      = 8;

   // Four 5-bit fields, MSB field first.
   typedef logic [FEAT_W-1:0] feat_word_t;

endpackage

// File: rtl/feat_fifo_mem.sv
// Feature FIFO storage: DEPTH x DATA_W register array, one write port,
// one asynchronous read port. Storage is deliberately left unreset.
module feat_fifo_mem #(
   parameter int unsigned DATA_W = 20,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write the addressed entry on an accepted push.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Combinational head read.
   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/feat_word_fifo.sv
// First-word-fall-through FIFO between the feature extractor and the
// 5-bit number unpacker. Optional occupancy/drop statistics are built
// when FEAT_FIFO_STATS_EN is defined.
module feat_word_fifo
   import vad_pkg::*;
#(
   parameter int unsigned DATA_W = FEAT_W,
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_req,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
`ifdef FEAT_FIFO_STATS_EN
   output logic [ADDR_W:0]   hwm,
   output logic [7:0]        drop_cnt,
`endif
   input  logic              clr_ovf
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic [CNT_W-1:0]  r_count, w_count_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic              w_push, w_pop, w_drop;
   logic [DATA_W-1:0] w_rdata;

   assign wr_ready = (r_count != CNT_W'(DEPTH));
   assign rd_valid = (r_count != '0);
   assign w_push   = wr_valid & wr_ready;
   assign w_pop    = rd_req & rd_valid;
   assign w_drop   = wr_valid & ~wr_ready;

   feat_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (wr_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // Empty FIFO presents zero so the reset value of rd_data is defined.
   assign rd_data  = rd_valid ? w_rdata : '0;
   assign count    = r_count;
   assign overflow = r_ovf;

   // Next-state for pointers, occupancy and sticky overflow.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      w_ovf_nxt    = r_ovf;
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
      if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
      else if (w_pop && !w_push) w_count_nxt = r_count - CNT_W'(1);
      if (w_drop)       w_ovf_nxt = 1'b1;
      else if (clr_ovf) w_ovf_nxt = 1'b0;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_ovf    <= w_ovf_nxt;
      end
   end

`ifdef FEAT_FIFO_STATS_EN
   logic [CNT_W-1:0] r_hwm, w_hwm_nxt;
   logic [7:0]       r_drop_cnt, w_drop_cnt_nxt;

   // High-water mark tracks registered count; drop counter saturates at 255.
   always_comb begin
      w_hwm_nxt      = r_hwm;
      w_drop_cnt_nxt = r_drop_cnt;
      if (clr_ovf) begin
         w_hwm_nxt      = r_count;
         w_drop_cnt_nxt = w_drop ? 8'd1 : 8'd0;
      end else begin
         if (r_count > r_hwm) w_hwm_nxt = r_count;
         if (w_drop && r_drop_cnt != 8'hFF) w_drop_cnt_nxt = r_drop_cnt + 8'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hwm      <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_hwm      <= w_hwm_nxt;
         r_drop_cnt <= w_drop_cnt_nxt;
      end
   end

   assign hwm      = r_hwm;
   assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_feat_word_fifo.sv
// Self-checking bench for feat_word_fifo (FEAT_FIFO_STATS_EN optional).
module tb_feat_word_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic [19:0] wr_data = '0;
   logic        wr_ready;
   logic        rd_req = 1'b0;
   logic [19:0] rd_data;
   logic        rd_valid;
   logic [3:0]  count;
   logic        overflow;
   logic        clr_ovf = 1'b0;
`ifdef FEAT_FIFO_STATS_EN
   logic [3:0]  hwm;
   logic [7:0]  drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   feat_word_fifo dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .overflow (overflow),
`ifdef FEAT_FIFO_STATS_EN
      .hwm      (hwm),
      .drop_cnt (drop_cnt),
`endif
      .clr_ovf  (clr_ovf)
   );

   typedef struct {
      logic        wv;
      logic [19:0] wd;
      logic        rr;
      logic        co;
      logic [3:0]  cnt;
      logic        vld;
      logic [19:0] dat;
      logic        rdy;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] c, input logic v,
                          input logic [19:0] d, input logic r, input logic o);
      chk({tag, " count"},    32'(count),    32'(c));
      chk({tag, " rd_valid"}, 32'(rd_valid), 32'(v));
      chk({tag, " rd_data"},  32'(rd_data),  32'(d));
      chk({tag, " wr_ready"}, 32'(wr_ready), 32'(r));
      chk({tag, " overflow"}, 32'(overflow), 32'(o));
   endtask

   // Drive one cycle of inputs from a negedge, return at the following negedge.
   task automatic step(input logic wv, input logic [19:0] wd, input logic rr, input logic co);
      wr_valid = wv; wr_data = wd; rd_req = rr; clr_ovf = co;
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0; rd_req = 1'b0; clr_ovf = 1'b0;
   endtask

   function automatic vec_t mk(logic wv, logic [19:0] wd, logic rr, logic co,
                               logic [3:0] c, logic v, logic [19:0] d, logic r, logic o);
      vec_t x;
      x.wv = wv; x.wd = wd; x.rr = rr; x.co = co;
      x.cnt = c; x.vld = v; x.dat = d; x.rdy = r; x.ovf = o;
      return x;
   endfunction

   initial begin
      // Single word, then drained; rd_req on empty is ignored.
      vecs.push_back(mk(1, 20'hABCDE, 0, 0, 1, 1, 20'hABCDE, 1, 0));
      vecs.push_back(mk(0, 20'h0,     0, 0, 1, 1, 20'hABCDE, 1, 0));
      vecs.push_back(mk(0, 20'h0,     1, 0, 0, 0, 20'h0,     1, 0));
      vecs.push_back(mk(0, 20'h0,     1, 0, 0, 0, 20'h0,     1, 0));
      // Fill to full, head stays at word 1.
      for (int k = 1; k <= 8; k++)
         vecs.push_back(mk(1, 20'(k), 0, 0, 4'(k), 1, 20'h1, (k != 8), 0));
      // Ninth write dropped, overflow set.
      vecs.push_back(mk(1, 20'h9, 0, 0, 8, 1, 20'h1, 0, 1));
      // Drain in order.
      for (int j = 1; j <= 8; j++)
         vecs.push_back(mk(0, 20'h0, 1, 0, 4'(8 - j), (j != 8),
                           (j != 8) ? 20'(j + 1) : 20'h0, 1, 1));
      // Clear overflow.
      vecs.push_back(mk(0, 20'h0, 0, 1, 0, 0, 20'h0, 1, 0));
   end

   initial begin
      wr_valid = 1'b0; rd_req = 1'b0; clr_ovf = 1'b0; rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_all("reset", 4'd0, 1'b0, 20'h0, 1'b1, 1'b0);
`ifdef FEAT_FIFO_STATS_EN
      chk("reset hwm", 32'(hwm), 32'd0);
      chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
`endif

      // Table-driven vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].co);
         chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].vld, vecs[i].dat,
                 vecs[i].rdy, vecs[i].ovf);
      end

      // Hold count=3 with simultaneous push/pop for 10 cycles; pointers wrap.
      for (int i = 0; i < 3; i++) step(1'b1, 20'(32'h100 + i), 1'b0, 1'b0);
      chk("steady pre count", 32'(count), 32'd3);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("steady head%0d", i), 32'(rd_data), 32'h100 + 32'(i));
         step(1'b1, 20'(32'h103 + i), 1'b1, 1'b0);
         chk($sformatf("steady count%0d", i), 32'(count), 32'd3);
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("steady drain%0d", i), 32'(rd_data), 32'h10A + 32'(i));
         step(1'b0, 20'h0, 1'b1, 1'b0);
      end
      chk_all("steady empty", 4'd0, 1'b0, 20'h0, 1'b1, 1'b0);

      // Full with simultaneous push/pop and clr_ovf: pop wins, write dropped, set beats clear.
      for (int i = 0; i < 8; i++) step(1'b1, 20'(32'h200 + i), 1'b0, 1'b0);
      chk_all("full", 4'd8, 1'b1, 20'h200, 1'b0, 1'b0);
      step(1'b1, 20'h2FF, 1'b1, 1'b1);
      chk_all("full pushpop", 4'd7, 1'b1, 20'h201, 1'b1, 1'b1);
`ifdef FEAT_FIFO_STATS_EN
      chk("full hwm", 32'(hwm), 32'd8);
      chk("full drop_cnt", 32'(drop_cnt), 32'd1);
`endif
      step(1'b0, 20'h0, 1'b0, 1'b1);
      chk("ovf cleared", 32'(overflow), 32'd0);
      for (int i = 1; i < 8; i++) begin
         chk($sformatf("full drain%0d", i), 32'(rd_data), 32'h200 + 32'(i));
         step(1'b0, 20'h0, 1'b1, 1'b0);
      end
      chk_all("full empty", 4'd0, 1'b0, 20'h0, 1'b1, 1'b0);

      // Reset mid-burst at count=5 with overflow set.
      for (int i = 0; i < 8; i++) step(1'b1, 20'(32'h300 + i), 1'b0, 1'b0);
      step(1'b1, 20'h3FF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 20'h0, 1'b1, 1'b0);
      chk_all("pre-reset", 4'd5, 1'b1, 20'h303, 1'b1, 1'b1);
      wr_valid = 1'b1; wr_data = 20'h3AA;
      #2 rst_n = 1'b0;
      #1;
      chk_all("async reset", 4'd0, 1'b0, 20'h0, 1'b1, 1'b0);
`ifdef FEAT_FIFO_STATS_EN
      chk("async reset hwm", 32'(hwm), 32'd0);
      chk("async reset drop_cnt", 32'(drop_cnt), 32'd0);
`endif
      @(negedge clk);
      wr_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk_all("post-reset", 4'd0, 1'b0, 20'h0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
